// File: rtl/mem_pkg.sv
// Shared encodings for the load return path.
// Holds memOp/memSize encodings, fault codes, region identifiers,
// default address map bounds, the pipeline metadata and FIFO entry
// records, and the inclusive address range helper.
package mem_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_SEXT  = 2'b01;
  localparam logic [1:0] OP_ZEXT  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_UNMAPPED = 2'b10,
    FLT_SIZE     = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'b00,
    RGN_BUF  = 2'b01,
    RGN_DIN  = 2'b10,
    RGN_NONE = 2'b11
  } region_e;

  localparam logic [31:0] DEF_CPU_BRAM_START = 32'h0000_0000;
  localparam logic [31:0] DEF_CPU_BRAM_END   = 32'h007F_FF00;
  localparam logic [31:0] DEF_BUF_BRAM_START = 32'h0100_0000;
  localparam logic [31:0] DEF_BUF_BRAM_END   = 32'h013F_FF00;
  localparam logic [31:0] DEF_DIN_REG        = 32'h0200_0000;

  // Request attributes carried alongside the read latency.
  typedef struct packed {
    logic       valid;
    logic [1:0] offset;
    logic [1:0] op;
    logic [1:0] size;
    region_e    region;
    fault_e     fault;
  } meta_t;

  typedef struct packed {
    logic [31:0] data;
    fault_e      fault;
  } rsp_t;

  // Taking the bounds as arguments keeps a zero lower bound from
  // turning into a constant-true comparison.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load data formatter.
// Orders the raw word into result lane order, selects the byte or
// halfword addressed by offset, and sign/zero-extends it.
// Ports:
//   raw    - 32-bit word returned by the selected region
//   offset - byte offset within the word (addr[1:0])
//   size   - memSize encoding
//   op     - memOp encoding (OP_SEXT sign-extends, anything else zero-extends)
//   data   - formatted 32-bit result
module load_formatter
  import mem_pkg::*;
#(
  parameter int SWAP_BYTES = 1
) (
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [1:0]  op,
  output logic [31:0] data
);

  logic [31:0] lanes;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        sext;

  // Once the word is in result lane order, byte k sits at lanes[8k+:8]
  // and halfword offset 2 at lanes[31:16] for both storage orders.
  assign lanes = (SWAP_BYTES != 0) ? {raw[7:0], raw[15:8], raw[23:16], raw[31:24]}
                                   : raw;
  assign sext  = (op == OP_SEXT);

  // NOTE: every output of an always_comb block gets a default first, so
  // no path through the case statements can infer a latch.
  always_comb begin
    half_sel = offset[1] ? lanes[31:16] : lanes[15:0];
    byte_sel = lanes[7:0];
    case (offset)
      2'd1:    byte_sel = lanes[15:8];
      2'd2:    byte_sel = lanes[23:16];
      2'd3:    byte_sel = lanes[31:24];
      default: byte_sel = lanes[7:0];
    endcase

    data = lanes;
    case (size)
      SZ_BYTE: data = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sext & half_sel[15]}}, half_sel};
      default: data = lanes;
    endcase
  end

endmodule

// File: rtl/load_return_unit.sv
// Pipelined load return unit.
// Accepts load requests, decodes the target region, strobes the region
// read for the accept cycle, waits READ_LAT cycles, formats the returned
// data and queues {data, fault} results in request order.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   req_valid/req_ready     - request handshake
//   req_addr/memOp/memSize  - request attributes
//   rd_en_ram/buf/din       - one-cycle region read strobes
//   rawMemRead/BufRead/DinRead - region read data, READ_LAT after strobe
//   rsp_valid/rsp_ready     - response handshake
//   rsp_data/rsp_fault      - registered head of the response FIFO
module load_return_unit
  import mem_pkg::*;
#(
  parameter int          READ_LAT       = 1,
  parameter int          DEPTH          = 2,
  parameter int          SWAP_BYTES     = 1,
  parameter logic [31:0] CPU_BRAM_START = DEF_CPU_BRAM_START,
  parameter logic [31:0] CPU_BRAM_END   = DEF_CPU_BRAM_END,
  parameter logic [31:0] BUF_BRAM_START = DEF_BUF_BRAM_START,
  parameter logic [31:0] BUF_BRAM_END   = DEF_BUF_BRAM_END,
  parameter logic [31:0] DIN_REG        = DEF_DIN_REG
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_memOp,
  input  logic [1:0]  req_memSize,
  output logic        rd_en_ram,
  output logic        rd_en_buf,
  output logic        rd_en_din,
  input  logic [31:0] rawMemRead,
  input  logic [31:0] rawBufRead,
  input  logic [31:0] rawDinRead,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_fault
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

  region_e       dec_region;
  fault_e        dec_fault;
  logic          accept, is_load, issue;
  logic [CW-1:0] credits_used;
  meta_t         pipe [READ_LAT];
  meta_t         last;
  logic [31:0]   sel_raw, fmt_data;
  rsp_t          push_entry, head_q, head_nxt;
  logic          push, pop;
  rsp_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] fifo_count, count_nxt;

  // ---------------- decode ----------------
  always_comb begin
    if (in_range(req_addr, CPU_BRAM_START, CPU_BRAM_END))      dec_region = RGN_RAM;
    else if (in_range(req_addr, BUF_BRAM_START, BUF_BRAM_END)) dec_region = RGN_BUF;
    else if (req_addr == DIN_REG)                              dec_region = RGN_DIN;
    else                                                       dec_region = RGN_NONE;

    if (req_memSize == SZ_ILL)
      dec_fault = FLT_SIZE;
    else if ((req_memSize == SZ_HALF && req_addr[0]) ||
             (req_memSize == SZ_WORD && req_addr[1:0] != 2'b00))
      dec_fault = FLT_MISALIGN;
    else if (dec_region == RGN_NONE)
      dec_fault = FLT_UNMAPPED;
    else
      dec_fault = FLT_OK;
  end

  // Credits cover every response still owed: in the pipeline or queued.
  // Gating with reset holds req_ready (and so every strobe) low in reset.
  assign req_ready = reset && (credits_used < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign is_load   = (req_memOp == OP_SEXT) || (req_memOp == OP_ZEXT);
  assign issue     = accept && is_load && (dec_fault == FLT_OK);
  assign rd_en_ram = issue && (dec_region == RGN_RAM);
  assign rd_en_buf = issue && (dec_region == RGN_BUF);
  assign rd_en_din = issue && (dec_region == RGN_DIN);

  // ---------------- latency pipeline ----------------
  // NOTE: state registers use non-blocking assignments so every stage
  // samples its predecessor's pre-edge value, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid:  accept && is_load,
                   offset: req_addr[1:0],
                   op:     req_memOp,
                   size:   req_memSize,
                   region: dec_region,
                   fault:  dec_fault};
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[READ_LAT-1];

  always_comb begin
    case (last.region)
      RGN_RAM: sel_raw = rawMemRead;
      RGN_BUF: sel_raw = rawBufRead;
      RGN_DIN: sel_raw = rawDinRead;
      default: sel_raw = '0;
    endcase
  end

  load_formatter #(.SWAP_BYTES(SWAP_BYTES)) u_fmt (
    .raw    (sel_raw),
    .offset (last.offset),
    .size   (last.size),
    .op     (last.op),
    .data   (fmt_data)
  );

  assign push_entry.data  = (last.fault == FLT_OK) ? fmt_data : 32'h0;
  assign push_entry.fault = last.fault;
  assign push             = last.valid;
  assign pop              = rsp_valid && rsp_ready;

  // ---------------- response FIFO ----------------
  // NOTE: the storage array has no reset; pointers and count are reset and
  // the registered head masks whatever stale words the array holds.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // The head register is loaded with what mem[rd_ptr] will hold after the
  // edge, bypassing the array when the pushed entry becomes the new head.
  always_comb begin
    count_nxt  = fifo_count + CW'(push) - CW'(pop);
    rd_ptr_nxt = rd_ptr;
    if (pop) rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    if (pop)
      head_nxt = (fifo_count > ONE_C) ? mem[rd_ptr_nxt] : push_entry;
    else
      head_nxt = (fifo_count == '0) ? push_entry : head_q;
    if (count_nxt == '0) head_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      credits_used <= '0;
      head_q       <= '0;
      rsp_valid    <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      rd_ptr       <= rd_ptr_nxt;
      fifo_count   <= count_nxt;
      credits_used <= credits_used + CW'(accept && is_load) - CW'(pop);
      head_q       <= head_nxt;
      rsp_valid    <= (count_nxt != '0);
    end
  end

  assign rsp_data  = head_q.data;
  assign rsp_fault = head_q.fault;

endmodule

// File: tb/tb_load_return_unit.sv
// Directed self-checking bench for load_return_unit with default
// parameters (READ_LAT=1, DEPTH=2, SWAP_BYTES=1).
module tb_load_return_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_memOp;
  logic [1:0]  req_memSize;
  logic        rd_en_ram, rd_en_buf, rd_en_din;
  logic [31:0] rawMemRead, rawBufRead, rawDinRead;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_return_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_memOp   (req_memOp),
    .req_memSize (req_memSize),
    .rd_en_ram   (rd_en_ram),
    .rd_en_buf   (rd_en_buf),
    .rd_en_din   (rd_en_din),
    .rawMemRead  (rawMemRead),
    .rawBufRead  (rawBufRead),
    .rawDinRead  (rawDinRead),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_fault   (rsp_fault)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  op;
    logic [1:0]  size;
    logic [31:0] raw;
    logic [2:0]  strb;   // {din, buf, ram}
    logic        rsp;
    logic [31:0] data;
    logic [1:0]  fault;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The addressed region gets the vector's word; the others get its
  // complement so a wrong region select shows up in the result.
  task automatic set_raw(input logic [2:0] strb, input logic [31:0] raw);
    rawMemRead = strb[0] ? raw : ~raw;
    rawBufRead = strb[1] ? raw : ~raw;
    rawDinRead = strb[2] ? raw : ~raw;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] op, input logic [1:0] size);
    req_valid   = 1'b1;
    req_addr    = addr;
    req_memOp   = op;
    req_memSize = size;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    rsp_ready = 1'b1;
    set_raw(v.strb, v.raw);
    drive(v.addr, v.op, v.size);
    #1;
    check($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
    check($sformatf("v%0d strobe", idx), {29'b0, rd_en_din, rd_en_buf, rd_en_ram}, {29'b0, v.strb});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check($sformatf("v%0d strobe_off", idx), {29'b0, rd_en_din, rd_en_buf, rd_en_ram}, 32'd0);
    check($sformatf("v%0d early_valid", idx), {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, {31'b0, v.rsp});
    if (v.rsp) begin
      check($sformatf("v%0d data", idx), rsp_data, v.data);
      check($sformatf("v%0d fault", idx), {30'b0, rsp_fault}, {30'b0, v.fault});
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("v%0d drained", idx), {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             addr          op     size   raw           strb    rsp   data          fault
    vecs[0]  = '{32'h0000_0010, 2'b01, 2'b10, 32'h1122_3344, 3'b001, 1'b1, 32'h4433_2211, 2'b00};
    vecs[1]  = '{32'h0100_0003, 2'b01, 2'b00, 32'h0000_0080, 3'b010, 1'b1, 32'hFFFF_FF80, 2'b00};
    vecs[2]  = '{32'h0100_0003, 2'b10, 2'b00, 32'h0000_0080, 3'b010, 1'b1, 32'h0000_0080, 2'b00};
    vecs[3]  = '{32'h0000_0002, 2'b01, 2'b01, 32'h0000_80FF, 3'b001, 1'b1, 32'hFFFF_FF80, 2'b00};
    vecs[4]  = '{32'h0000_0001, 2'b01, 2'b01, 32'h0000_80FF, 3'b000, 1'b1, 32'h0000_0000, 2'b01};
    vecs[5]  = '{32'h0300_0000, 2'b01, 2'b10, 32'h1234_5678, 3'b000, 1'b1, 32'h0000_0000, 2'b10};
    vecs[6]  = '{32'h0000_0010, 2'b01, 2'b11, 32'h1234_5678, 3'b000, 1'b1, 32'h0000_0000, 2'b11};
    vecs[7]  = '{32'h0200_0000, 2'b11, 2'b10, 32'h1234_5678, 3'b000, 1'b0, 32'h0000_0000, 2'b00};
    vecs[8]  = '{32'h0200_0000, 2'b10, 2'b10, 32'hA1B2_C3D4, 3'b100, 1'b1, 32'hD4C3_B2A1, 2'b00};
    vecs[9]  = '{32'h0000_0000, 2'b10, 2'b00, 32'h1122_3344, 3'b001, 1'b1, 32'h0000_0011, 2'b00};
    vecs[10] = '{32'h0000_0004, 2'b01, 2'b01, 32'h1122_3344, 3'b001, 1'b1, 32'h0000_2211, 2'b00};
    vecs[11] = '{32'h0100_0001, 2'b01, 2'b00, 32'h00F0_0000, 3'b010, 1'b1, 32'hFFFF_FFF0, 2'b00};
    vecs[12] = '{32'h007F_FF00, 2'b10, 2'b10, 32'h8899_AABB, 3'b001, 1'b1, 32'hBBAA_9988, 2'b00};
    vecs[13] = '{32'h007F_FF04, 2'b10, 2'b10, 32'h8899_AABB, 3'b000, 1'b1, 32'h0000_0000, 2'b10};
    vecs[14] = '{32'h013F_FF00, 2'b01, 2'b00, 32'h7F00_0000, 3'b010, 1'b1, 32'h0000_007F, 2'b00};
    vecs[15] = '{32'h0200_0004, 2'b10, 2'b10, 32'h1234_5678, 3'b000, 1'b1, 32'h0000_0000, 2'b10};
    vecs[16] = '{32'h0000_0012, 2'b10, 2'b10, 32'h1234_5678, 3'b000, 1'b1, 32'h0000_0000, 2'b01};
    vecs[17] = '{32'h0300_0001, 2'b01, 2'b01, 32'h1234_5678, 3'b000, 1'b1, 32'h0000_0000, 2'b01};
    vecs[18] = '{32'h0000_0003, 2'b01, 2'b11, 32'h1234_5678, 3'b000, 1'b1, 32'h0000_0000, 2'b11};
    vecs[19] = '{32'h0200_0000, 2'b00, 2'b10, 32'h1234_5678, 3'b000, 1'b0, 32'h0000_0000, 2'b00};
    vecs[20] = '{32'h0100_0002, 2'b10, 2'b01, 32'h1234_8765, 3'b010, 1'b1, 32'h0000_6587, 2'b00};

    // Reset state, with a request offered to show nothing is accepted.
    reset       = 1'b0;
    rsp_ready   = 1'b0;
    set_raw(3'b000, 32'h0);
    drive(32'h0000_0010, 2'b01, 2'b10);
    #12;
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst req_ready", {31'b0, req_ready}, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst rsp_fault", {30'b0, rsp_fault}, 32'd0);
    check("rst strobes", {29'b0, rd_en_din, rd_en_buf, rd_en_ram}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

    // Backpressure: two credits, third request held off until a pop.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_raw(3'b001, 32'h4433_2211);
    drive(32'h0000_0000, 2'b10, 2'b00);
    #1 check("bp ready0", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(32'h0000_0001, 2'b10, 2'b00);
    #1 check("bp ready1", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(32'h0000_0002, 2'b10, 2'b00);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp full_ready c%0d", c), {31'b0, req_ready}, 32'd0);
      check($sformatf("bp full_strobe c%0d", c), {31'b0, rd_en_ram}, 32'd0);
      check($sformatf("bp head_valid c%0d", c), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp head0 c%0d", c), rsp_data, 32'h0000_0044);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp head1 valid", {31'b0, rsp_valid}, 32'd1);
    check("bp head1", rsp_data, 32'h0000_0033);
    check("bp ready again", {31'b0, req_ready}, 32'd1);
    check("bp third strobe", {31'b0, rd_en_ram}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("bp gap", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp head2 valid", {31'b0, rsp_valid}, 32'd1);
    check("bp head2", rsp_data, 32'h0000_0022);
    @(posedge clk);
    @(negedge clk);
    #1 check("bp drained", {31'b0, rsp_valid}, 32'd0);

    // Reset with one response queued and one in the pipeline.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_raw(3'b001, 32'h1122_3344);
    drive(32'h0000_0010, 2'b01, 2'b10);
    @(posedge clk);
    @(negedge clk);
    drive(32'h0000_0014, 2'b01, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("rr pre valid", {31'b0, rsp_valid}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rr valid", {31'b0, rsp_valid}, 32'd0);
    check("rr ready", {31'b0, req_ready}, 32'd0);
    check("rr data", rsp_data, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check($sformatf("rr stale c%0d", c), {31'b0, rsp_valid}, 32'd0);
    end
    run_vec(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_return_unit.md
Name: load_return_unit

Overview:
- Pipelined, parametrised successor to the combinational load-data formatter.
- Accepts load requests on a valid/ready handshake and decodes the target region (CPU BRAM, buffer BRAM, DIN register).
- Issues a one-cycle read strobe to the selected region and waits a configurable synchronous read latency.
- Selects, byte-orders and sign/zero-extends the returned data, then queues results in an output FIFO with fault codes instead of X values.

Parameters:
- READ_LAT, 1, cycles from read strobe to valid raw data; legal range 1..4.
- DEPTH, 2, maximum requests in flight plus queued; legal range 1..8.
- SWAP_BYTES, 1, 1 = little-endian storage to big-endian result; 0 = pass-through lane order.
- CPU_BRAM_START / CPU_BRAM_END, 32'h0000_0000 / 32'h007F_FF00, inclusive CPU BRAM byte range.
- BUF_BRAM_START / BUF_BRAM_END, 32'h0100_0000 / 32'h013F_FF00, inclusive buffer BRAM byte range.
- DIN_REG, 32'h0200_0000, exact DIN register address.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address.
- req_memOp  in  2  00 disable, 01 read sext, 10 read zext, 11 write.
- req_memSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- rd_en_ram / rd_en_buf / rd_en_din  out  1 each  read strobes.
- rawMemRead / rawBufRead / rawDinRead  in  32 each  region read data, valid READ_LAT cycles after the strobe.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  32  formatted load data.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 unmapped, 11 illegal size.

Behaviour:
- **Reset (reset=0, async):**
  - All pipeline valid bits and FIFO pointers/count clear.
  - rsp_valid=0, rsp_data=0, rsp_fault=0, req_ready=0, rd_en_*=0.
  - Any in-flight request is discarded and produces no response.
- **Ready and accept:**
  - req_ready=1 iff (in-flight + queued) < DEPTH.
  - A request is accepted on req_valid & req_ready.
  - memOp 00 or 11: request is consumed but produces no strobe and no response.
- **Decode at accept, in priority order:**
  - memSize=11 → fault 11.
  - halfword with addr[0]=1, or word with addr[1:0]≠0 → fault 01.
  - No region match → fault 10.
  - Otherwise the matching rd_en_* pulses for exactly the accept cycle; the strobe is combinational from accept.
  - Faulted requests issue no strobe.
- **Pipeline and capture:**
  - Metadata (addr[1:0], op, size, region, fault) shifts through a READ_LAT-stage pipeline.
  - At stage READ_LAT, raw data of the stored region is sampled and formatted.
  - The result is pushed into the FIFO. Faulted entries carry data 0.
  - Results stay in request order, faulted entries included.
- **Formatting, SWAP_BYTES=1** (b0=raw[7:0] … b3=raw[31:24]):
  - word = {b0,b1,b2,b3}.
  - halfword offset 0 = {b2,b3}; offset 2 = {b0,b1}.
  - byte offset k = b(3-k).
- **Formatting, SWAP_BYTES=0:**
  - word = raw.
  - halfword offset 0 = raw[15:0]; offset 2 = raw[31:16].
  - byte offset k = raw[8k+7:8k].
- **Extension:** op 01 sign-extends from the selected field MSB; op 10 zero-extends.
- **Output FIFO:**
  - rsp_valid=1 iff the FIFO is non-empty; rsp_data/rsp_fault show the head entry, registered.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - The in-flight credit is returned on pop, so the FIFO can never overflow even with rsp_ready held low.
- **Throughput and latency:**
  - Back-to-back accepts are allowed every cycle while credits remain.
  - Accept-to-rsp_valid latency = READ_LAT+1 cycles when the FIFO is empty.

Decomposition:
- Package mem_pkg holds:
  - memOp/memSize encodings.
  - fault codes.
  - region enum (RAM, BUF, DIN, NONE).
  - default region bounds.
- Sub-module load_formatter: combinational byte select, byte swap and extension.
- Generic FIFO storage stays inline.

Test Plan:
- Word sext at 0x10, rawMemRead=32'h1122_3344, READ_LAT=1 → rd_en_ram one cycle; rsp_data=32'h4433_2211, fault 00, rsp_valid 2 cycles after accept.
- Byte at 0x0100_0003, rawBufRead=32'h0000_0080 → sext gives 32'hFFFF_FF80; zext gives 32'h0000_0080; rd_en_buf only.
- Halfword sext at 0x2, raw 32'h0000_80FF → 32'hFFFF_FF80; halfword at 0x1 → fault 01, data 0, no strobe.
- Read at 0x0300_0000 → fault 10.
- memSize=11 → fault 11.
- Write op at DIN_REG → no rd_en_din and no response.
- DEPTH=2 with rsp_ready=0: 3 back-to-back requests → req_ready drops after 2 accepts; release rsp_ready → both responses in order, then the third is accepted.
- Assert reset with 2 requests in flight → rsp_valid=0 immediately; after release, no stale responses appear.
